// File: rtl/subtractor_skla_pipe_pkg.sv
// Shared helpers for the Sklansky prefix-tree family: level count and
// per-bit block geometry used to wire each prefix level.
package subtractor_skla_pipe_pkg;

  function automatic int prefix_levels(input int width);
    return (width <= 1) ? 0 : $clog2(width);
  endfunction

  // Bit k sits in the upper half of its 2^(level+1) block and combines with the lower half.
  function automatic bit in_upper_half(input int level, input int k);
    return ((k >> level) & 1) == 1;
  endfunction

  function automatic int block_start(input int level, input int k);
    return (k >> level) << level;
  endfunction

  // Groups covering bit 0 already hold final carries, so their propagate is no longer needed.
  function automatic bit anchored(input int level, input int k);
    return (k >> (level + 1)) == 0;
  endfunction

endpackage

// File: rtl/skla_prefix_stage.sv
// One registered Sklansky prefix level: merges each upper-half bit with the
// top bit of the lower half of its block, and forwards side data unchanged.
module skla_prefix_stage
  import subtractor_skla_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEVEL = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             vld,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH+1:0] side,
  output logic             vld_reg,
  output logic [WIDTH-1:0] g_reg,
  output logic [WIDTH-1:0] p_reg,
  output logic [WIDTH+1:0] side_reg
);

  logic [WIDTH-1:0] g_lvl;
  logic [WIDTH-1:0] p_lvl;

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    if (in_upper_half(LEVEL, k)) begin : g_upper
      localparam int SRC = block_start(LEVEL, k) - 1;
      assign g_lvl[k] = g[k] | (p[k] & g[SRC]);
      if (anchored(LEVEL, k)) begin : g_anch
        assign p_lvl[k] = p[k];
      end else begin : g_free
        assign p_lvl[k] = p[k] & p[SRC];
      end
    end else begin : g_pass
      assign g_lvl[k] = g[k];
      assign p_lvl[k] = p[k];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_reg  <= 1'b0;
      g_reg    <= '0;
      p_reg    <= '0;
      side_reg <= '0;
    end else if (en) begin
      vld_reg  <= vld;
      g_reg    <= g_lvl;
      p_reg    <= p_lvl;
      side_reg <= side;
    end
  end

endmodule

// File: rtl/subtractor_skla_pipe.sv
// Pipelined Sklansky subtractor: a - b - bi computed as a + ~b + ~bi, with one
// register after p/g generation, one per prefix level and one at the output.
module subtractor_skla_pipe
  import subtractor_skla_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH:0]   d,
  output logic             ov
);

  localparam int GP = prefix_levels(WIDTH);

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic diff_msb);
    return (a_msb ^ b_msb) & (a_msb ^ diff_msb);
  endfunction

  logic en;
  assign en      = ~m_valid | m_ready;
  assign s_ready = en;

  logic [WIDTH-1:0] b_inv;
  logic [WIDTH-1:0] p_gen;
  logic [WIDTH-1:0] g_gen;
  logic [WIDTH-1:0] hs_gen;

  always_comb begin
    b_inv     = ~b;
    p_gen     = a ^ b_inv;
    g_gen     = a & b_inv;
    g_gen[0]  = maj3(a[0], b_inv[0], ~bi);
    // The half-sum word keeps the raw propagate, except bit 0 which is already the final sum.
    hs_gen    = p_gen;
    hs_gen[0] = p_gen[0] ^ ~bi;
  end

  // Stage 0: p/g generation
  logic             vld_p0;
  logic [WIDTH-1:0] g_p0;
  logic [WIDTH-1:0] p_p0;
  logic [WIDTH+1:0] side_p0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p0  <= 1'b0;
      g_p0    <= '0;
      p_p0    <= '0;
      side_p0 <= '0;
    end else if (en) begin
      vld_p0  <= s_valid;
      g_p0    <= g_gen;
      p_p0    <= p_gen;
      side_p0 <= {a[WIDTH-1], b[WIDTH-1], hs_gen};
    end
  end

  // Stages 1..GP: one Sklansky level each
  logic             vld_lv  [0:GP];
  logic [WIDTH-1:0] g_lv    [0:GP];
  logic [WIDTH-1:0] p_lv    [0:GP];
  logic [WIDTH+1:0] side_lv [0:GP];

  assign vld_lv[0]  = vld_p0;
  assign g_lv[0]    = g_p0;
  assign p_lv[0]    = p_p0;
  assign side_lv[0] = side_p0;

  for (genvar l = 0; l < GP; l++) begin : g_level
    skla_prefix_stage #(
      .WIDTH (WIDTH),
      .LEVEL (l)
    ) u_stage (
      .clk      (clk),
      .resetn   (resetn),
      .en       (en),
      .vld      (vld_lv[l]),
      .g        (g_lv[l]),
      .p        (p_lv[l]),
      .side     (side_lv[l]),
      .vld_reg  (vld_lv[l+1]),
      .g_reg    (g_lv[l+1]),
      .p_reg    (p_lv[l+1]),
      .side_reg (side_lv[l+1])
    );
  end

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] hs_fin;
  logic [WIDTH-1:0] diff_fin;
  logic             a_msb_fin;
  logic             b_msb_fin;
  logic             bo_fin;
  logic             ov_fin;

  always_comb begin
    carry     = g_lv[GP];
    hs_fin    = side_lv[GP][WIDTH-1:0];
    a_msb_fin = side_lv[GP][WIDTH+1];
    b_msb_fin = side_lv[GP][WIDTH];
    diff_fin  = hs_fin;
    for (int i = 1; i < WIDTH; i++) begin
      diff_fin[i] = hs_fin[i] ^ carry[i-1];
    end
    bo_fin = ~carry[WIDTH-1];
    ov_fin = sub_overflow(a_msb_fin, b_msb_fin, diff_fin[WIDTH-1]);
  end

  // Final stage: sum and flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0;
      d       <= '0;
      ov      <= 1'b0;
    end else if (en) begin
      m_valid <= vld_lv[GP];
      d       <= {bo_fin, diff_fin};
      ov      <= ov_fin;
    end
  end

endmodule

// File: doc/subtractor_skla_pipe.md
Name: subtractor_skla_pipe

Overview:
Pipelined Sklansky parallel-prefix subtractor computing a − b − bi; the inverse-direction counterpart of the combinational Sklansky adder in the arithmetic library. It forms a + ~b + ~bi and registers the result after the p/g generation stage and after every prefix level. Valid/ready streaming interfaces on both sides let it drop into datapaths that need a high-Fmax wide subtract with borrow and overflow reporting.

Parameters:
WIDTH, 16, operand width in bits (≥1); GP = $clog2(WIDTH) prefix levels, a localparam.

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
s_valid  input  1  operand beat valid
s_ready  output  1  operand beat accepted when s_valid & s_ready
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bi  input  1  borrow in
m_valid  output  1  result valid
m_ready  input  1  downstream accepts result
d  output  WIDTH+1  {bo, diff}: bo = borrow out, diff = (a − b − bi) mod 2^WIDTH
ov  output  1  two's-complement signed overflow of a − b − bi

Behaviour:
- Reset (resetn=0, async assert, sync deassert by the surrounding design): all stage valid bits = 0, m_valid = 0, d = 0, ov = 0; data registers are cleared to 0. A reset mid-operation discards every in-flight beat; no beat emerges afterwards.
- Pipeline: stage 0 registers p0 = a ^ ~b, g0 = a & ~b, with bit 0 g0[0] = majority(a[0], ~b[0], ~bi); also registers p0[0] ^ ~bi (sum bit 0), a[WIDTH−1], and b[WIDTH−1]. Stages 1..GP each register one Sklansky level: for level i, for each block starting at j = 2^i, stepping 2^(i+1), with k in [0, 2^i): g' = g | (p & g[j−1]); p' = p & p[j−1] for groups not anchored at bit 0. Other bits pass through. The final stage registers diff[i] = p0[i] ^ G[i−1] (i ≥ 1), carry c = G[WIDTH−1], bo = ~c, ov = (a_msb ^ b_msb) & (a_msb ^ diff_msb).
- Latency: exactly GP+2 cycles from the accept edge to m_valid with no stall. For WIDTH=16 the latency is 6; for WIDTH=1 (GP=0) it is 2.
- Throughput: one beat per cycle when m_ready = 1.
- Flow control: global enable en = ~m_valid | m_ready. s_ready = en, combinational. When en = 0, every stage (data and valid) holds. When en = 1, all stages advance, and each valid bit shifts in the previous stage's valid bit (stage 0 takes s_valid).
- Bubbles: while m_valid = 0 the pipeline always advances, so bubbles never block. Internal bubbles are not collapsed.
- Output stability: while m_valid = 1 and m_ready = 0, d and ov are held stable. Beat order is preserved and no beat is ever dropped or duplicated.
- Operand capture: a, b, and bi are sampled only on the accept edge. Values on cycles without s_valid & s_ready are ignored; those data registers may load but their valid bit is 0.
- Arithmetic: unsigned result. bo = 1 iff a < b + bi, with d[WIDTH] = bo. ov is valid for signed interpretation only.

Decomposition:
- Shared package (arith_pkg): function clog2-safe level count, and the prefix-level index helpers (block start and group-anchored predicate) shared with the combinational adder family.
- One sub-module: skla_prefix_stage (parameters WIDTH and LEVEL). It is a registered single Sklansky level with enable and async active-low reset, instantiated GP times in a generate loop.
- P/G generation and the sum/flag stage stay in the top module.

Test Plan:
- WIDTH=16, a=0x0005, b=0x0003, bi=0, m_ready=1 -> after 6 cycles m_valid=1, d=0x0_0002, ov=0.
- a=0x0000, b=0x0001, bi=0 -> d=0x1_FFFF (bo=1), ov=0. Also a=0x1234, b=0x1234, bi=1 -> d=0x1_FFFF.
- a=0x8000, b=0x0001, bi=0 -> d=0x0_7FFF, ov=1. Also a=0x7FFF, b=0xFFFF -> d=0x1_8000, ov=1.
- Streaming: 20 back-to-back random beats with m_ready=1 -> 20 results in order, one per cycle, each matching the reference model, with first-result latency 6.
- Backpressure: m_ready=0 for 4 cycles while the pipe is full -> s_ready=0, d/m_valid held stable. After m_ready returns, no loss or duplication occurs, checked by scoreboard over 1000 random beats with random s_valid/m_ready.
- Assert resetn=0 with 3 beats in flight -> m_valid and d are 0 immediately (async). After release, no stale beat appears; a new beat 0xFFFF−0x0001 returns 0x0_FFFE after 6 cycles. Repeat for WIDTH=1 and WIDTH=13 (latency 2 and 6).
